// File: rtl/zero_unary_exec.sv
// rtl/zero_unary_exec.sv - clocked execution core for Zero unary test programs
// Optional step budget: define ZERO_STEP_LIMIT_EN (adds parameter MAXSTEPS).
module zero_unary_exec #(
    parameter int WIDTH  = 12,
    parameter int NLOCAL = 8,
    parameter int NPROG  = 16,
    parameter int NOUT   = 4
`ifdef ZERO_STEP_LIMIT_EN
    ,
    parameter int MAXSTEPS = 64
`endif
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 prog_we,
    input  logic [$clog2(NPROG)-1:0]             prog_addr,
    input  logic [3+2*$clog2(NLOCAL)+WIDTH-1:0]  prog_data,
    input  logic                                 start,
    input  logic                                 in_valid,
    input  logic [WIDTH-1:0]                     in_data,
    output logic                                 in_ready,
    output logic                                 out_valid,
    output logic [WIDTH-1:0]                     out_data,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 finished,
    output logic                                 fault,
    output logic [15:0]                          steps
);

    localparam int AW = $clog2(NLOCAL);
    localparam int PW = $clog2(NPROG);
    localparam int IW = 3 + 2 * AW + WIDTH;
    localparam int FW = $clog2(NOUT);
    localparam int CW = FW + 1;
    localparam logic [PW-1:0] IP_LAST   = PW'(NPROG - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(NOUT);

    localparam logic [2:0] OP_HALT = 3'd0;
    localparam logic [2:0] OP_MOVI = 3'd1;
    localparam logic [2:0] OP_MOV  = 3'd2;
    localparam logic [2:0] OP_NOT  = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;
    localparam logic [2:0] OP_OUT  = 3'd5;
    localparam logic [2:0] OP_IN   = 3'd6;
    localparam logic [2:0] OP_JNZ  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_OUT_WAIT, S_IN_WAIT, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ip_q, ip_d;
    logic [15:0]     steps_q, steps_d;
    logic            fault_q, fault_d;
    logic [FW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [IW-1:0]    prog_mem_q  [NPROG];
    logic [WIDTH-1:0] local_mem_q [NLOCAL];
    logic [WIDTH-1:0] fifo_mem_q  [NOUT];

    logic [IW-1:0]    instr;
    logic [2:0]       op;
    logic [AW-1:0]    dst, src;
    logic [WIDTH-1:0] imm, src_val;
    logic             lm_we, push, pop, can_push, retire, adv;
    logic [WIDTH-1:0] lm_wdata;

    assign instr   = prog_mem_q[ip_q];
    assign op      = instr[IW-1 -: 3];
    assign dst     = instr[IW-4 -: AW];
    assign src     = instr[WIDTH+AW-1 -: AW];
    assign imm     = instr[WIDTH-1:0];
    assign src_val = local_mem_q[src];

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? fifo_mem_q[rd_ptr_q] : '0;
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign can_push  = (count_q != FIFO_FULL) || pop;

    assign in_ready = ((state_q == S_EXEC) || (state_q == S_IN_WAIT)) && (op == OP_IN);
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign finished = (state_q == S_DONE);
    assign fault    = fault_q;
    assign steps    = steps_q;

    always_comb begin
        state_d  = state_q;
        ip_d     = ip_q;
        steps_d  = steps_q;
        fault_d  = fault_q;
        lm_we    = 1'b0;
        lm_wdata = imm;
        push     = 1'b0;
        retire   = 1'b0;
        adv      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_EXEC;
                    ip_d    = '0;
                    steps_d = '0;
                    fault_d = 1'b0;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_HALT: begin
                        retire  = 1'b1;
                        state_d = S_DONE;
                    end
                    OP_MOVI: begin
                        lm_we = 1'b1; lm_wdata = imm; retire = 1'b1; adv = 1'b1;
                    end
                    OP_MOV: begin
                        lm_we = 1'b1; lm_wdata = src_val; retire = 1'b1; adv = 1'b1;
                    end
                    OP_NOT: begin
                        lm_we    = 1'b1;
                        lm_wdata = (src_val == '0) ? WIDTH'(1) : '0;
                        retire   = 1'b1;
                        adv      = 1'b1;
                    end
                    OP_INV: begin
                        lm_we = 1'b1; lm_wdata = ~src_val; retire = 1'b1; adv = 1'b1;
                    end
                    OP_OUT: begin
                        if (can_push) begin
                            push = 1'b1; retire = 1'b1; adv = 1'b1;
                        end else begin
                            state_d = S_OUT_WAIT;
                        end
                    end
                    OP_IN: begin
                        if (in_valid) begin
                            lm_we = 1'b1; lm_wdata = in_data; retire = 1'b1; adv = 1'b1;
                        end else begin
                            state_d = S_IN_WAIT;
                        end
                    end
                    default: begin
                        retire = 1'b1;
                        if (src_val != '0) ip_d = imm[PW-1:0];
                        else               adv  = 1'b1;
                    end
                endcase
            end
            S_IN_WAIT: begin
                if (in_valid) begin
                    lm_we    = 1'b1;
                    lm_wdata = in_data;
                    retire   = 1'b1;
                    adv      = 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_OUT_WAIT: begin
                // ip still points at the OUT; EXEC re-issues it next cycle.
                if (can_push) state_d = S_EXEC;
            end
            default: state_d = S_IDLE;
        endcase
        if (adv) begin
            if (ip_q == IP_LAST) state_d = S_DONE;
            else                 ip_d    = ip_q + PW'(1);
        end
        if (retire && (steps_q != 16'hFFFF)) steps_d = steps_q + 16'd1;
`ifdef ZERO_STEP_LIMIT_EN
        if (retire && (steps_d == 16'(MAXSTEPS)) && (state_d != S_DONE)) begin
            state_d = S_DONE;
            fault_d = 1'b1;
        end
`endif
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + FW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + FW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ip_q     <= '0;
            steps_q  <= '0;
            fault_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            ip_q     <= ip_d;
            steps_q  <= steps_d;
            fault_q  <= fault_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Program memory survives reset so a loaded program can be rerun.
    always_ff @(posedge clock) begin
        if (prog_we && ((state_q == S_IDLE) || (state_q == S_DONE)))
            prog_mem_q[prog_addr] <= prog_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NLOCAL; i++) local_mem_q[i] <= '0;
        end else if (lm_we) begin
            local_mem_q[dst] <= lm_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem_q[wr_ptr_q] <= src_val;
    end

endmodule

// File: tb/tb_zero_unary_exec.sv
// tb/tb_zero_unary_exec.sv - directed table and sequence bench for zero_unary_exec
module tb_zero_unary_exec;

    localparam logic [2:0] OP_HALT = 3'd0;
    localparam logic [2:0] OP_MOVI = 3'd1;
    localparam logic [2:0] OP_MOV  = 3'd2;
    localparam logic [2:0] OP_NOT  = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;
    localparam logic [2:0] OP_OUT  = 3'd5;
    localparam logic [2:0] OP_IN   = 3'd6;
    localparam logic [2:0] OP_JNZ  = 3'd7;

    logic        clock, reset, prog_we, start, in_valid, in_ready;
    logic [3:0]  prog_addr;
    logic [20:0] prog_data;
    logic [11:0] in_data, out_data;
    logic        out_valid, out_ready, busy, finished, fault;
    logic [15:0] steps;

    int checks = 0;
    int errors = 0;
    logic [11:0] outq [$];

    typedef struct {
        logic [2:0]  op;
        logic [11:0] pre;
        logic [11:0] imm;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs [7];

    zero_unary_exec #(
        .WIDTH(12), .NLOCAL(8), .NPROG(16), .NOUT(2)
`ifdef ZERO_STEP_LIMIT_EN
        , .MAXSTEPS(10)
`endif
    ) dut (
        .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .finished(finished), .fault(fault),
        .steps(steps)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) outq.push_back(out_data);
    end

    function automatic logic [20:0] ins(input logic [2:0] op, input logic [2:0] d,
                                        input logic [2:0] s, input logic [11:0] imm);
        return {op, d, s, imm};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic [11:0] exp);
        logic [11:0] v;
        checks++;
        if (outq.size() == 0) begin
            errors++;
            $display("FAIL %s actual=none required=%0h", name, exp);
        end else begin
            v = outq.pop_front();
            if (v !== exp) begin
                errors++;
                $display("FAIL %s actual=%0h required=%0h", name, v, exp);
            end
        end
    endtask

    task automatic load(input int a, input logic [20:0] w);
        prog_we   = 1'b1;
        prog_addr = 4'(a);
        prog_data = w;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (finished !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(finished), 32'd1);
        repeat (3) tick();
    endtask

    task automatic load_p1();
        load(0, ins(OP_MOVI, 3'd0, 3'd0, 12'd3));
        load(1, ins(OP_NOT,  3'd1, 3'd0, 12'd0));
        load(2, ins(OP_NOT,  3'd2, 3'd1, 12'd0));
        load(3, ins(OP_OUT,  3'd0, 3'd0, 12'd0));
        load(4, ins(OP_OUT,  3'd0, 3'd1, 12'd0));
        load(5, ins(OP_OUT,  3'd0, 3'd2, 12'd0));
        load(6, ins(OP_HALT, 3'd0, 3'd0, 12'd0));
    endtask

    initial begin
        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        vecs[0] = '{OP_MOVI, 12'h111, 12'hABC, 12'hABC};
        vecs[1] = '{OP_MOV,  12'h123, 12'h7FF, 12'h123};
        vecs[2] = '{OP_NOT,  12'h000, 12'h7FF, 12'h001};
        vecs[3] = '{OP_NOT,  12'h005, 12'h000, 12'h000};
        vecs[4] = '{OP_NOT,  12'h800, 12'h000, 12'h000};
        vecs[5] = '{OP_INV,  12'h000, 12'h7FF, 12'hFFF};
        vecs[6] = '{OP_INV,  12'hA5A, 12'h000, 12'h5A5};

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_finished",  32'(finished),  32'd0);
        check("rst_fault",     32'(fault),     32'd0);
        check("rst_steps",     32'(steps),     32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);

        // single-op table: MOVI r2,pre ; <op> r3,r2 ; OUT r3 ; HALT
        for (int i = 0; i < 7; i++) begin
            outq.delete();
            load(0, ins(OP_MOVI, 3'd2, 3'd0, vecs[i].pre));
            load(1, ins(vecs[i].op, 3'd3, 3'd2, vecs[i].imm));
            load(2, ins(OP_OUT, 3'd0, 3'd3, 12'd0));
            load(3, ins(OP_HALT, 3'd0, 3'd0, 12'd0));
            pulse_start();
            wait_done($sformatf("vec%0d_done", i), 40);
            expect_out($sformatf("vec%0d_out", i), vecs[i].exp);
            check($sformatf("vec%0d_steps", i), 32'(steps), 32'd4);
        end

        // logical/bitwise chain with free-running consumer
        outq.delete();
        load_p1();
        pulse_start();
        wait_done("p1_done", 40);
        expect_out("p1_out0", 12'd3);
        expect_out("p1_out1", 12'd0);
        expect_out("p1_out2", 12'd1);
        check("p1_steps", 32'(steps), 32'd7);

        // same program with consumer stalled: FIFO fills, core parks on third OUT
        outq.delete();
        out_ready = 1'b0;
        pulse_start();
        repeat (10) tick();
        check("p2_stall_steps", 32'(steps),     32'd5);
        check("p2_stall_busy",  32'(busy),      32'd1);
        check("p2_stall_valid", 32'(out_valid), 32'd1);
        check("p2_stall_fin",   32'(finished),  32'd0);
        pulse_start();
        check("p2_start_ignored", 32'(steps), 32'd5);
        load(6, ins(OP_OUT, 3'd0, 3'd0, 12'd0));
        out_ready = 1'b1;
        wait_done("p2_done", 40);
        check("p2_count", 32'(outq.size()), 32'd3);
        expect_out("p2_out0", 12'd3);
        expect_out("p2_out1", 12'd0);
        expect_out("p2_out2", 12'd1);
        check("p2_steps", 32'(steps), 32'd7);

        // input stall: IN r0 ; INV r1,r0 ; OUT r1 ; HALT
        outq.delete();
        load(0, ins(OP_IN,   3'd0, 3'd0, 12'd0));
        load(1, ins(OP_INV,  3'd1, 3'd0, 12'd0));
        load(2, ins(OP_OUT,  3'd0, 3'd1, 12'd0));
        load(3, ins(OP_HALT, 3'd0, 3'd0, 12'd0));
        pulse_start();
        repeat (3) tick();
        check("p3_in_ready", 32'(in_ready), 32'd1);
        check("p3_wait_steps", 32'(steps), 32'd0);
        in_valid = 1'b1;
        in_data  = 12'h0F0;
        tick();
        in_valid = 1'b0;
        in_data  = 12'h000;
        wait_done("p3_done", 40);
        expect_out("p3_out", 12'hF0F);
        check("p3_steps", 32'(steps), 32'd4);

        // countdown via register shift and JNZ loop
        outq.delete();
        load(0, ins(OP_MOVI, 3'd0, 3'd0, 12'd3));
        load(1, ins(OP_MOVI, 3'd1, 3'd0, 12'd2));
        load(2, ins(OP_MOVI, 3'd2, 3'd0, 12'd1));
        load(3, ins(OP_MOVI, 3'd3, 3'd0, 12'd0));
        load(4, ins(OP_OUT,  3'd0, 3'd0, 12'd0));
        load(5, ins(OP_MOV,  3'd0, 3'd1, 12'd0));
        load(6, ins(OP_MOV,  3'd1, 3'd2, 12'd0));
        load(7, ins(OP_MOV,  3'd2, 3'd3, 12'd0));
        load(8, ins(OP_JNZ,  3'd0, 3'd0, 12'd4));
        load(9, ins(OP_HALT, 3'd0, 3'd0, 12'd0));
        pulse_start();
        wait_done("p4_done", 80);
        expect_out("p4_out0", 12'd3);
        expect_out("p4_out1", 12'd2);
`ifdef ZERO_STEP_LIMIT_EN
        check("p4_steps", 32'(steps), 32'd10);
        check("p4_fault", 32'(fault), 32'd1);
`else
        expect_out("p4_out2", 12'd1);
        check("p4_steps", 32'(steps), 32'd20);
        check("p4_fault", 32'(fault), 32'd0);
`endif
        check("p4_no_extra", 32'(outq.size()), 32'd0);

        // far JNZ target (upper imm bits ignored) and running off the last word
        outq.delete();
        load(0,  ins(OP_MOVI, 3'd6, 3'd0, 12'd1));
        load(1,  ins(OP_JNZ,  3'd0, 3'd6, 12'h3FE));
        load(14, ins(OP_MOVI, 3'd7, 3'd0, 12'd7));
        load(15, ins(OP_OUT,  3'd0, 3'd7, 12'd0));
        pulse_start();
        check("p5_fault_cleared", 32'(fault), 32'd0);
        wait_done("p5_done", 40);
        expect_out("p5_out", 12'd7);
        check("p5_steps", 32'(steps), 32'd4);

        // tight infinite loop: MOVI r0,1 ; JNZ r0,1
        load(0, ins(OP_MOVI, 3'd0, 3'd0, 12'd1));
        load(1, ins(OP_JNZ,  3'd0, 3'd0, 12'd1));
        pulse_start();
`ifdef ZERO_STEP_LIMIT_EN
        wait_done("p6_done", 40);
        check("p6_fault", 32'(fault), 32'd1);
        check("p6_steps", 32'(steps), 32'd10);
        pulse_start();
        check("p6_restart_fault", 32'(fault), 32'd0);
        check("p6_restart_busy",  32'(busy),  32'd1);
        wait_done("p6_redone", 40);
`else
        repeat (30) tick();
        check("p6_fault", 32'(fault),    32'd0);
        check("p6_busy",  32'(busy),     32'd1);
        check("p6_fin",   32'(finished), 32'd0);
        check("p6_steps", 32'(steps),    32'd30);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // reset while parked in OUT_WAIT with a full FIFO, then rerun
        outq.delete();
        load_p1();
        out_ready = 1'b0;
        pulse_start();
        repeat (10) tick();
        check("p7_pre_valid", 32'(out_valid), 32'd1);
        check("p7_pre_busy",  32'(busy),      32'd1);
        check("p7_pre_steps", 32'(steps),     32'd5);
        reset = 1'b1;
        tick();
        check("p7_rst_valid", 32'(out_valid), 32'd0);
        check("p7_rst_busy",  32'(busy),      32'd0);
        check("p7_rst_steps", 32'(steps),     32'd0);
        reset = 1'b0;
        tick();
        outq.delete();
        out_ready = 1'b1;
        pulse_start();
        wait_done("p7_done", 40);
        expect_out("p7_out0", 12'd3);
        expect_out("p7_out1", 12'd0);
        expect_out("p7_out2", 12'd1);
        check("p7_steps", 32'(steps), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
